inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Parametrised instruction buffer between the inst SRAM fetch path and the dual-issue decode stage.
- Decouples multi-instruction fetch beats from the per-cycle issue count.
- Accepts up to FETCH_W instructions per cycle and presents up to ISSUE_W oldest instructions, with their PCs, to decode.
- Supports whole-queue flush on redirect (branch, exception, eret).

Parameters:
- FETCH_W, 2, instructions per fetch beat (1..4).
- ISSUE_W, 2, maximum instructions dequeued per cycle (1..FETCH_W).
- DEPTH, 16, queue entries; power of two, at least 2*FETCH_W.

Ports:
- clk  in  1  core clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all entries; redirect from the datapath.
- in_valid  in  1  fetch beat present.
- in_pc  in  32  PC of lane 0; lane i PC = in_pc + 4*i.
- in_inst  in  32*FETCH_W  instruction words; lane i at bits [32i+31:32i].
- in_count  in  $clog2(FETCH_W)+1  valid lanes in the beat, lanes 0..in_count-1.
- in_ready  out  1  free entries >= FETCH_W.
- out_valid  out  ISSUE_W  thermometer; bit i set when entry head+i exists.
- out_pc  out  32*ISSUE_W  PC of entry head+i.
- out_inst  out  32*ISSUE_W  instruction of entry head+i.
- out_take  in  $clog2(ISSUE_W)+1  entries consumed this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage is a circular buffer. head/tail pointers are $clog2(DEPTH)+1 bits with a wrap bit; slot index = ptr mod DEPTH.
- Enqueue: when in_valid && in_ready, write in_count entries at tail..tail+in_count-1, then advance tail by in_count. in_count=0 is a no-op. in_count>FETCH_W is clamped to FETCH_W.
- in_ready depends only on registered count (DEPTH-count >= FETCH_W), never on out_take. A beat offered while in_ready=0 is dropped. The fetch stage must hold the beat.
- Dequeue: head advances by min(out_take, popcount(out_valid)); excess take is clamped, never underflows.
- out_valid[i] = (count > i). out_pc/out_inst lanes with out_valid[i]=0 drive 0.
- Outputs come combinationally from head-side storage. Without bypass, enqueue-to-visible latency is 1 cycle.
- Simultaneous enqueue and dequeue are legal in any mix: count_next = count + enq - deq. A full queue with take=2 and in_ready=0 accepts nothing that cycle.
- Wrap-around: multi-lane writes and reads that straddle slot DEPTH-1 -> 0 split correctly. Verify with DEPTH=16, FETCH_W=2, tail at slot 15.
- flush has highest priority. In the flush cycle, enqueue and dequeue are ignored. Next cycle: head=tail=0, count=0, out_valid=0, in_ready=1.
- Reset (resetn low, async): head=tail=0, count=0, out_valid=0, out_pc/out_inst=0, in_ready=1. Storage array is not reset. Reset mid-operation discards all contents immediately.
- No state machine beyond pointer/count registers.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when count==0 and in_valid && in_ready, lanes 0..min(in_count,ISSUE_W)-1 drive out_* combinationally in the same cycle. Bypassed lanes consumed by out_take are not written; the remainder are written at the tail. flush still suppresses everything.
- Undefined: minimum latency is 1 cycle and there is no in_* -> out_* combinational path.

Decomposition:
- Shared package cpu_pkg holds:
  - constant INST_W=32;
  - typedef ifq_entry_t {pc[31:0], inst[31:0]};
  - pointer-width helper function.
- One sub-module, ifq_ram: DEPTH x ifq_entry_t array with FETCH_W write ports (indexed tail+i) and ISSUE_W combinational read ports (indexed head+i).
- Pointer, count and bypass logic stay in the top.

Test Plan:
- Reset then single beat (in_pc=0xBFC00000, in_count=2, inst A,B) -> next cycle out_valid=2'b11, out_pc=0xBFC00000/0xBFC00004, count=2; take=2 -> count=0.
- Fill with out_take=0 (8 beats of 2) -> count=16, in_ready=0; extra beat dropped; take=1 -> count=15, in_ready stays 0 (free 1 < 2).
- Wrap: advance pointers to tail=15, enqueue 2 -> slots 15 and 0 written; dequeue order preserves PC sequence.
- Simultaneous: count=3, enqueue 2 and take 2 same cycle -> count=3, head moves 2, FIFO order intact.
- Flush with in_valid=1 and take=2 at count=5 -> next cycle count=0, out_valid=0, nothing enqueued.
- in_count=1 (unaligned fetch, PC 0x...04) -> only one entry; out_take=2 clamped to 1; with IFQ_BYPASS_EN the entry appears the same cycle when the queue is empty.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction width, the fetch-queue
// entry payload, and the pointer-width helper used by the fetch queue.
// Ports: none (package).
package cpu_pkg;

  localparam int unsigned INST_W = 32;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } ifq_entry_t;

  // Circular-buffer pointer width: slot index plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifq_ram.sv
// Fetch-queue storage: DEPTH entries, FETCH_W write ports, ISSUE_W
// combinational read ports. Contents are deliberately not reset.
// Ports:
//   clk      - core clock
//   i_we     - per-lane write enable
//   i_waddr  - per-lane write slot
//   i_wdata  - per-lane entry payload
//   i_raddr  - per-lane read slot
//   o_rdata  - per-lane read payload (combinational)
module ifq_ram
  import cpu_pkg::*;
#(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                                    clk,
  input  logic [FETCH_W-1:0]                      i_we,
  input  logic [FETCH_W-1:0][$clog2(DEPTH)-1:0]   i_waddr,
  input  ifq_entry_t [FETCH_W-1:0]                i_wdata,
  input  logic [ISSUE_W-1:0][$clog2(DEPTH)-1:0]   i_raddr,
  output ifq_entry_t [ISSUE_W-1:0]                o_rdata
);

  ifq_entry_t r_mem [DEPTH];

  // Lanes always target distinct slots, so port order is irrelevant.
  always_ff @(posedge clk) begin
    for (int j = 0; j < int'(FETCH_W); j++) begin
      if (i_we[j]) r_mem[i_waddr[j]] <= i_wdata[j];
    end
  end

  always_comb begin
    for (int i = 0; i < int'(ISSUE_W); i++) begin
      o_rdata[i] = r_mem[i_raddr[i]];
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the multi-lane fetch path and decode.
// Accepts up to FETCH_W instructions per beat and presents the ISSUE_W
// oldest entries with their PCs. Flush empties the queue on redirect.
// Optional macro IFQ_BYPASS_EN: when the queue is empty, an accepted beat
// is presented to decode in the same cycle; lanes taken that cycle are
// never written.
// Ports:
//   clk, resetn           - clock, async active-low reset
//   flush                 - discard everything (highest priority)
//   in_valid/in_pc/in_inst/in_count - fetch beat, lane i PC = in_pc + 4*i
//   in_ready              - at least FETCH_W free entries
//   out_valid/out_pc/out_inst - thermometer of oldest entries and payload
//   out_take              - entries consumed this cycle (clamped)
//   count                 - current occupancy
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [31:0]                 in_pc,
  input  logic [INST_W*FETCH_W-1:0]   in_inst,
  input  logic [$clog2(FETCH_W):0]    in_count,
  output logic                        in_ready,
  output logic [ISSUE_W-1:0]          out_valid,
  output logic [32*ISSUE_W-1:0]       out_pc,
  output logic [INST_W*ISSUE_W-1:0]   out_inst,
  input  logic [$clog2(ISSUE_W):0]    out_take,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned IDX_W = PTR_W - 1;
  localparam int unsigned ICW   = $clog2(FETCH_W) + 1;

  logic [PTR_W-1:0] r_head, r_tail, r_count;

  logic             w_fire;
  logic [PTR_W-1:0] w_enq_n, w_avail, w_take, w_deq, w_skip;

  logic [FETCH_W-1:0]            w_we;
  logic [FETCH_W-1:0][IDX_W-1:0] w_waddr;
  ifq_entry_t [FETCH_W-1:0]      w_wdata;
  logic [ISSUE_W-1:0][IDX_W-1:0] w_raddr;
  ifq_entry_t [ISSUE_W-1:0]      w_rdata;

  // Acceptance depends only on registered occupancy, never on out_take.
  assign in_ready = (PTR_W'(DEPTH) - r_count) >= PTR_W'(FETCH_W);
  assign count    = r_count;

  // Enqueue/dequeue amounts, both clamped; flush cancels both.
  always_comb begin
    w_fire  = in_valid && in_ready && !flush;
    w_enq_n = '0;
    if (w_fire) begin
      w_enq_n = (in_count > ICW'(FETCH_W)) ? PTR_W'(FETCH_W) : PTR_W'(in_count);
    end
    w_avail = (r_count > PTR_W'(ISSUE_W)) ? PTR_W'(ISSUE_W) : r_count;
    w_take  = PTR_W'(out_take);
    w_deq   = '0;
    if (!flush) w_deq = (w_take < w_avail) ? w_take : w_avail;
  end

`ifdef IFQ_BYPASS_EN
  logic [PTR_W-1:0] w_byp_n;

  // Lanes shown straight from the beat; those also taken skip storage.
  always_comb begin
    w_byp_n = '0;
    if (w_fire && (r_count == '0)) begin
      w_byp_n = (w_enq_n > PTR_W'(ISSUE_W)) ? PTR_W'(ISSUE_W) : w_enq_n;
    end
    w_skip = (w_take < w_byp_n) ? w_take : w_byp_n;
  end
`else
  assign w_skip = '0;
`endif

  // Lane j lands at tail + (j - skip); lanes below skip were consumed.
  always_comb begin
    for (int j = 0; j < int'(FETCH_W); j++) begin
      w_we[j]    = w_fire && (PTR_W'(j) < w_enq_n) && (PTR_W'(j) >= w_skip);
      w_waddr[j] = IDX_W'(r_tail + PTR_W'(j) - w_skip);
      w_wdata[j] = '{pc: in_pc + 32'(4 * j), inst: in_inst[INST_W*j +: INST_W]};
    end
    for (int i = 0; i < int'(ISSUE_W); i++) begin
      w_raddr[i] = IDX_W'(r_head + PTR_W'(i));
    end
  end

  ifq_ram #(
    .FETCH_W (FETCH_W),
    .ISSUE_W (ISSUE_W),
    .DEPTH   (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Head-side presentation; absent lanes drive zero.
  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_inst  = '0;
    for (int i = 0; i < int'(ISSUE_W); i++) begin
      if (r_count > PTR_W'(i)) begin
        out_valid[i]               = 1'b1;
        out_pc[32*i +: 32]         = w_rdata[i].pc;
        out_inst[INST_W*i +: INST_W] = w_rdata[i].inst;
      end
`ifdef IFQ_BYPASS_EN
      if (PTR_W'(i) < w_byp_n) begin
        out_valid[i]               = 1'b1;
        out_pc[32*i +: 32]         = in_pc + 32'(4 * i);
        out_inst[INST_W*i +: INST_W] = in_inst[INST_W*i +: INST_W];
      end
`endif
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_deq;
      r_tail  <= r_tail + w_enq_n - w_skip;
      r_count <= r_count + w_enq_n - w_skip - w_deq;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue (FETCH_W=2, ISSUE_W=2, DEPTH=16).
// Accepted entries are queued at issue time; a monitor pops and compares
// every lane decode consumes. Directed checks cover occupancy and flags.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [63:0] in_inst;
  logic [1:0]  in_count;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_inst;
  logic [1:0]  out_take;
  logic [4:0]  count;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  inst_fetch_queue #(.FETCH_W(2), .ISSUE_W(2), .DEPTH(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_count  (in_count),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_take  (out_take),
    .count     (count)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {8'h24, pc[23:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every lane consumed this cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (resetn && !flush) begin
      for (int i = 0; i < 2; i++) begin
        if ((i < int'(out_take)) && out_valid[i]) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_underflow lane%0d: got pc %h expected no entry", i, out_pc[32*i +: 32]);
          end else begin
            chk($sformatf("deq_lane%0d", i), {out_pc[32*i +: 32], out_inst[32*i +: 32]}, sb.pop_front());
          end
        end
      end
    end
  end

  // One cycle: drive after posedge, settle at negedge; acc = bench expects acceptance.
  task automatic step(input logic v, input logic [31:0] pc, input logic [1:0] cnt,
                      input logic [1:0] take, input logic fl, input logic acc);
    @(posedge clk); #1;
    in_valid = v;
    in_pc    = pc;
    in_count = cnt;
    in_inst  = {inst_of(pc + 32'd4), inst_of(pc)};
    out_take = take;
    flush    = fl;
    if (acc) begin
      for (int i = 0; i < 2 && i < int'(cnt); i++) begin
        sb.push_back({pc + 32'(4 * i), inst_of(pc + 32'(4 * i))});
      end
    end
    @(negedge clk); #1;
    if (fl) sb.delete();
  endtask

  task automatic idle(input logic [1:0] take);
    step(1'b0, 32'h0, 2'd0, take, 1'b0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0;
    in_inst = '0; in_count = '0; out_take = '0;
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_pc", out_pc, 64'd0);
    #9 resetn = 1'b1;

    // Single beat, visible next cycle, then fully consumed.
    step(1'b1, 32'hBFC0_0000, 2'd2, 2'd0, 1'b0, 1'b1);
    chk("beat_same_cycle_cnt", 64'(count), 64'd0);
    idle(2'd0);
    chk("beat_valid", 64'(out_valid), 64'h3);
    chk("beat_pc", out_pc, 64'hBFC0_0004_BFC0_0000);
    chk("beat_inst", out_inst, 64'h24C0_0004_24C0_0000);
    chk("beat_count", 64'(count), 64'd2);
    idle(2'd2);
    idle(2'd0);
    chk("beat_drained", 64'(count), 64'd0);
    chk("empty_pc_zero", out_pc, 64'd0);

    // Fill to 16, drop an extra beat, take one: still not ready.
    for (int k = 0; k < 8; k++) step(1'b1, 32'h1000 + 32'(8 * k), 2'd2, 2'd0, 1'b0, 1'b1);
    step(1'b1, 32'hDEAD_0000, 2'd2, 2'd0, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd16);
    chk("full_ready", 64'(in_ready), 64'd0);
    idle(2'd1);
    chk("full_drop", 64'(count), 64'd16);
    idle(2'd0);
    chk("take1_count", 64'(count), 64'd15);
    chk("take1_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 7; k++) idle(2'd2);
    idle(2'd1);
    idle(2'd0);
    chk("fill_drained", 64'(count), 64'd0);

    // Move pointers to slot 15, then straddle the wrap.
    for (int k = 0; k < 6; k++) step(1'b1, 32'h3000 + 32'(8 * k), 2'd2, 2'd0, 1'b0, 1'b1);
    step(1'b1, 32'h3030, 2'd1, 2'd0, 1'b0, 1'b1);
    idle(2'd0);
    chk("pre_wrap_count", 64'(count), 64'd13);
    for (int k = 0; k < 6; k++) idle(2'd2);
    idle(2'd1);
    step(1'b1, 32'h8000_0000, 2'd2, 2'd0, 1'b0, 1'b1);
    step(1'b1, 32'h8000_0008, 2'd2, 2'd0, 1'b0, 1'b1);
    idle(2'd0);
    chk("wrap_count", 64'(count), 64'd4);
    chk("wrap_pc0", out_pc, 64'h8000_0004_8000_0000);
    idle(2'd2);
    idle(2'd0);
    chk("wrap_pc1", out_pc, 64'h8000_000C_8000_0008);
    idle(2'd2);
    idle(2'd0);
    chk("wrap_drained", 64'(count), 64'd0);

    // Simultaneous enqueue 2 / dequeue 2 at occupancy 3.
    step(1'b1, 32'h9000_0000, 2'd2, 2'd0, 1'b0, 1'b1);
    step(1'b1, 32'h9000_0008, 2'd1, 2'd0, 1'b0, 1'b1);
    step(1'b1, 32'h9000_0010, 2'd2, 2'd2, 1'b0, 1'b1);
    chk("simul_pre_count", 64'(count), 64'd3);
    idle(2'd0);
    chk("simul_count", 64'(count), 64'd3);
    chk("simul_pc", out_pc, 64'h9000_0010_9000_0008);

    // Flush at occupancy 5 with a beat and a take pending.
    step(1'b1, 32'h9000_0018, 2'd2, 2'd0, 1'b0, 1'b1);
    step(1'b1, 32'hA000_0000, 2'd2, 2'd2, 1'b1, 1'b0);
    chk("preflush_count", 64'(count), 64'd5);
    idle(2'd0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);

    // in_count above FETCH_W clamps to two lanes.
    step(1'b1, 32'hC000_0000, 2'd3, 2'd0, 1'b0, 1'b1);
    idle(2'd0);
    chk("clamp_count", 64'(count), 64'd2);
    idle(2'd2);

    // Unaligned single-lane fetch, over-take clamped.
    step(1'b1, 32'hBFC0_0004, 2'd1, 2'd0, 1'b0, 1'b1);
`ifdef IFQ_BYPASS_EN
    chk("byp_valid", 64'(out_valid), 64'h1);
    chk("byp_pc", 64'(out_pc[31:0]), 64'hBFC0_0004);
`else
    chk("nobyp_valid", 64'(out_valid), 64'd0);
`endif
    idle(2'd2);
    chk("one_count", 64'(count), 64'd1);
    chk("one_valid", 64'(out_valid), 64'h1);
    chk("one_lane1_zero", 64'(out_pc[63:32]), 64'd0);
    idle(2'd0);
    chk("overtake_count", 64'(count), 64'd0);

    step(1'b1, 32'hBFC0_0010, 2'd1, 2'd2, 1'b0, 1'b1);
    idle(2'd2);
`ifdef IFQ_BYPASS_EN
    chk("byp_consumed_count", 64'(count), 64'd0);
`else
    chk("nobyp_take_count", 64'(count), 64'd1);
`endif
    idle(2'd0);
    chk("single_drained", 64'(count), 64'd0);

    // Asynchronous reset in mid-cycle discards contents at once.
    step(1'b1, 32'hD000_0000, 2'd2, 2'd0, 1'b0, 1'b1);
    idle(2'd0);
    chk("prereset_count", 64'(count), 64'd2);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    sb.delete();
    @(negedge clk); #1;
    resetn = 1'b1;
    idle(2'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
